sobel_window_receiver: RTL
==========================

Name: sobel_window_receiver

Overview:
- Parametrised successor of the fixed 3x3/24-bit image receiver.
- Accepts a 64-bit image header and then a row-major RGB pixel stream over valid/ready handshakes.
- Converts each pixel to grayscale, keeps K-1 line buffers and emits one KxK grayscale window for every interior window position (no padding) to the Sobel core.
- Sits between the SD-card pixel unpacker and the Sobel engine; adds backpressure, header validation and a drain/complete sequence.

Parameters:
PIX_W, 8, grayscale and per-channel RGB width in bits
K, 3, window edge (odd, 3..7)
MAX_WIDTH, 640, line-buffer depth; largest legal image width
MAX_HEIGHT, 480, largest legal image height
GRAY_MODE, 0, 0 = take blue channel pix_data[PIX_W-1:0]; 1 = (R + 2G + B) >> 2

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  synchronous active-low reset
header_valid  in  1  header_data is valid
header_data  in  64  [63:32] width, [31:0] height in pixels
header_ready  out  1  block is idle and will take a header
header_error  out  1  last offered header was illegal (sticky until next header)
pix_valid  in  1  pix_data is valid
pix_data  in  3*PIX_W  {R,G,B}, R in the MSBs
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
win_valid  out  1  win_data holds a window
win_data  out  K*K*PIX_W  element (i,j) at [(i*K+j)*PIX_W +: PIX_W]; i = row (0 = top), j = column (0 = left)
win_ready  in  1  consumer takes the window
win_row  out  32  top-left row of the current window
win_col  out  32  top-left column of the current window
r_address  out  32  pixels accepted in the current frame
image_size  out  32  width*height latched at header accept
image_complete  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (n_rst low at a rising edge, including mid-frame):
  - State returns to IDLE.
  - All outputs, counters and the window register clear to 0.
  - Line-buffer contents need not clear.
- States:
  - IDLE: header_ready=1. On header_valid, check 2 <= K <= width <= MAX_WIDTH and K <= height <= MAX_HEIGHT.
    - Legal: latch width and height, image_size <= width*height, header_error <= 0, clear row/col/r_address, go to LOAD.
    - Illegal: header_error <= 1, stay in IDLE.
  - LOAD: pix_ready = !(win_valid && !win_ready). On each accept at (row r, col c):
    - Gray value is computed in PIX_W+2 bits, result truncated to PIX_W.
    - Window register shifts left one column. New right column = line buffers at column c (oldest on top) plus the new gray pixel at the bottom.
    - Line buffers shift the gray pixel in at column c.
    - r_address increments; col wraps at width-1 and then row increments.
    - If r >= K-1 and c >= K-1: in the next cycle win_valid=1, win_data = the new window, win_row = r-K+1, win_col = c-K+1.
    - Accepting the last pixel (r_address == image_size-1) moves to DRAIN.
  - DRAIN: pix_ready=0. Wait until win_valid==0, then go to DONE.
  - DONE: image_complete=1 for exactly one cycle, then IDLE. r_address and image_size hold until the next header.
- Output register: win_valid, once set, holds win_data, win_row and win_col stable until win_ready. win_valid clears on a handshake unless a new window is loaded in the same cycle.
- Windows never straddle row boundaries: stale columns from the previous row are shifted out before c reaches K-1.
- Window count per frame = (width-K+1)*(height-K+1).
- A header offered while not in IDLE is ignored (header_ready=0).
- pix_valid outside LOAD is ignored.
- Latency: one cycle from the accept of the completing pixel to win_valid.

Decomposition:
- Package sobel_pkg:
  - state enum (IDLE, LOAD, DRAIN, DONE);
  - header field offset constants;
  - function gray_f(rgb, mode).
- Sub-module line_buffer_bank (K-1 x MAX_WIDTH x PIX_W): single write column and read column per cycle, shift-down between rows. Window register and FSM stay in the top.

Test Plan:
- Header 64'h0000000400000004, GRAY_MODE=0, K=3, pix_data = {16'h0, index 0..15}, win_ready=1:
  - win_valid first rises the cycle after pixel 10 is accepted, with rows {0,1,2},{4,5,6},{8,9,10} and win_row=0, win_col=0.
  - Exactly 4 windows are produced.
  - image_complete pulses once after pixel 15; image_size=16.
- Header 64'h0000003000000030, pix_data=24'h232323, GRAY_MODE=1: 2116 windows with all 9 bytes 8'h23; r_address ends at 2304.
- Same 4x4 frame with win_ready held low 5 cycles at the first window: pix_ready drops, window data stays stable, no pixel or window is lost, all 4 windows are still delivered.
- Header width=2: header_error=1, header_ready stays 1, pixels ignored. A following legal header clears header_error.
- n_rst low for 1 cycle after pixel 7 of a 4x4 frame: state is IDLE, win_valid=0, r_address=0. A new 4x4 frame then yields the correct 4 windows.
- Pixel offered every other cycle (pix_valid toggling): window values are identical to the back-to-back case.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window receiver: FSM states,
// header field layout and the RGB-to-grayscale conversion.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  localparam int HDR_WIDTH_LSB  = 32;
  localparam int HDR_HEIGHT_LSB = 0;
  localparam int HDR_FIELD_W    = 32;

  // Widest channel supported by gray_f; callers zero-extend narrower pixels.
  localparam int GRAY_MAX_W = 16;

  typedef struct packed {
    logic [GRAY_MAX_W-1:0] r;
    logic [GRAY_MAX_W-1:0] g;
    logic [GRAY_MAX_W-1:0] b;
  } rgb_t;

  function automatic logic [GRAY_MAX_W+1:0] gray_f(input rgb_t rgb, input logic mode);
    logic [GRAY_MAX_W+1:0] sum;
    sum = {2'b00, rgb.r} + {1'b0, rgb.g, 1'b0} + {2'b00, rgb.b};
    return mode ? (sum >> 2) : {2'b00, rgb.b};
  endfunction

endpackage

// File: rtl/sobel_window_receiver_line_buffer_bank.sv
// K-1 grayscale line buffers; entry 0 holds the oldest row. One column is
// read and rewritten per accepted pixel, shifting that column down a row.
module line_buffer_bank
  import sobel_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int K         = 3,
  parameter int MAX_WIDTH = 640,
  parameter int COL_W     = $clog2(MAX_WIDTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [COL_W-1:0]       i_col,
  input  logic [PIX_W-1:0]       i_din,
  output logic [(K-1)*PIX_W-1:0] o_col
);

  logic [PIX_W-1:0] r_mem [K-1][MAX_WIDTH];

  always_comb begin
    o_col = '0;
    for (int k = 0; k < K - 1; k++) begin
      o_col[k*PIX_W +: PIX_W] = r_mem[k][i_col];
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < K - 2; k++) begin
        r_mem[k][i_col] <= r_mem[k+1][i_col];
      end
      r_mem[K-2][i_col] <= i_din;
    end
  end

endmodule

// File: rtl/sobel_window_receiver.sv
// Header-validated RGB pixel receiver that converts to grayscale and emits
// every interior KxK window to the Sobel core over a valid/ready handshake.
module sobel_window_receiver
  import sobel_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int K          = 3,
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480,
  parameter int GRAY_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 header_valid,
  input  logic [63:0]          header_data,
  output logic                 header_ready,
  output logic                 header_error,
  input  logic                 pix_valid,
  input  logic [3*PIX_W-1:0]   pix_data,
  output logic                 pix_ready,
  output logic                 win_valid,
  output logic [K*K*PIX_W-1:0] win_data,
  input  logic                 win_ready,
  output logic [31:0]          win_row,
  output logic [31:0]          win_col,
  output logic [31:0]          r_address,
  output logic [31:0]          image_size,
  output logic                 image_complete
);

  localparam int          COL_W = $clog2(MAX_WIDTH);
  localparam int          WIN_W = K * K * PIX_W;
  localparam logic [31:0] KM1   = 32'(K - 1);

  state_t r_state;
  state_t w_stateNext;

  logic [31:0]          r_width;
  logic [31:0]          r_height;
  logic [31:0]          r_row;
  logic [31:0]          r_col;
  logic [WIN_W-1:0]     r_win;
  logic [WIN_W-1:0]     w_winNext;
  logic [31:0]          w_hdrWidth;
  logic [31:0]          w_hdrHeight;
  logic                 w_hdrLegal;
  logic                 w_pixReady;
  logic                 w_accept;
  logic                 w_winLoad;
  logic                 w_lastPix;
  logic                 w_lastRow;
  rgb_t                 w_rgb;
  logic [PIX_W-1:0]     w_gray;
  logic [(K-1)*PIX_W-1:0] w_lbCol;

  assign w_hdrWidth  = header_data[HDR_WIDTH_LSB  +: HDR_FIELD_W];
  assign w_hdrHeight = header_data[HDR_HEIGHT_LSB +: HDR_FIELD_W];
  assign w_hdrLegal  = (w_hdrWidth >= 32'(K)) && (w_hdrWidth >= 32'd2) &&
                       (w_hdrWidth <= 32'(MAX_WIDTH)) &&
                       (w_hdrHeight >= 32'(K)) && (w_hdrHeight <= 32'(MAX_HEIGHT));

  assign w_rgb.r = GRAY_MAX_W'(pix_data[2*PIX_W +: PIX_W]);
  assign w_rgb.g = GRAY_MAX_W'(pix_data[PIX_W +: PIX_W]);
  assign w_rgb.b = GRAY_MAX_W'(pix_data[0 +: PIX_W]);
  assign w_gray  = PIX_W'(gray_f(w_rgb, GRAY_MODE != 0));

  // An unconsumed window blocks new pixels so it can never be overwritten.
  assign w_pixReady = (r_state == LOAD) && !(win_valid && !win_ready);
  assign pix_ready  = w_pixReady;
  assign w_accept   = pix_valid && w_pixReady;
  assign w_winLoad  = w_accept && (r_row >= KM1) && (r_col >= KM1);
  assign w_lastPix  = (r_address == image_size - 32'd1);
  assign w_lastRow  = (r_row == r_height - 32'd1);
  assign win_data   = r_win;

  line_buffer_bank #(
    .PIX_W    (PIX_W),
    .K        (K),
    .MAX_WIDTH(MAX_WIDTH),
    .COL_W    (COL_W)
  ) u_lines (
    .clk  (clk),
    .i_we (w_accept),
    .i_col(r_col[COL_W-1:0]),
    .i_din(w_gray),
    .o_col(w_lbCol)
  );

  always_comb begin
    w_winNext = r_win;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_winNext[(i*K+j)*PIX_W +: PIX_W] = r_win[(i*K+j+1)*PIX_W +: PIX_W];
      end
    end
    for (int i = 0; i < K - 1; i++) begin
      w_winNext[(i*K+K-1)*PIX_W +: PIX_W] = w_lbCol[i*PIX_W +: PIX_W];
    end
    w_winNext[((K-1)*K+K-1)*PIX_W +: PIX_W] = w_gray;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    header_ready   = 1'b0;
    image_complete = 1'b0;
    unique case (r_state)
      IDLE: begin
        header_ready = 1'b1;
        if (header_valid && w_hdrLegal) w_stateNext = LOAD;
      end
      LOAD: begin
        if (w_accept && w_lastPix) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (!win_valid) w_stateNext = DONE;
      end
      DONE: begin
        image_complete = 1'b1;
        w_stateNext    = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_width      <= '0;
      r_height     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_win        <= '0;
      r_address    <= '0;
      image_size   <= '0;
      header_error <= 1'b0;
      win_valid    <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      if (r_state == IDLE && header_valid) begin
        if (w_hdrLegal) begin
          r_width      <= w_hdrWidth;
          r_height     <= w_hdrHeight;
          image_size   <= w_hdrWidth * w_hdrHeight;
          header_error <= 1'b0;
          r_row        <= '0;
          r_col        <= '0;
          r_address    <= '0;
        end else begin
          header_error <= 1'b1;
        end
      end

      if (w_accept) begin
        r_win     <= w_winNext;
        r_address <= r_address + 32'd1;
        if (r_col == r_width - 32'd1) begin
          r_col <= '0;
          r_row <= w_lastRow ? r_row : r_row + 32'd1;
        end else begin
          r_col <= r_col + 32'd1;
        end
      end

      if (w_winLoad) begin
        win_valid <= 1'b1;
        win_row   <= r_row - KM1;
        win_col   <= r_col - KM1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule
